led_blink_seq: RTL and testbench
================================

LED_BLINK_SEQ -- requirements
Module: led_blink_seq

Interface
REQ-001 The block SHALL have parameter DIV, default 25000000, meaning clock cycles per tick (2..2^29-1).
REQ-002 The block SHALL have parameter ON_TICKS, default 1, meaning ticks the LED stays on per blink (>=1).
REQ-003 The block SHALL have parameter OFF_TICKS, default 1, meaning ticks the LED stays off per blink (>=1).
REQ-004 The block SHALL have parameter PAUSE_TICKS, default 4, meaning gap ticks between repeated sequences (>=1, used only with the macro).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: a request to begin a sequence, sampled each edge.
REQ-008 The block SHALL have port blink_num, input, 4 bits: blinks per sequence, latched on accepted start.
REQ-009 The block SHALL have port repeat, input, 1 bit: auto-restart request, honoured only with the macro.
REQ-010 The block SHALL have port led, output, 1 bit: the LED drive.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a sequence runs.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse at sequence end.
REQ-013 The block SHALL have port count, output, 29 bits: the live prescaler value.
REQ-014 The block SHALL have port blinks_left, output, 4 bits: blinks remaining, including the current one.

Function
REQ-015 The FSM SHALL have states IDLE, ON, OFF, plus PAUSE only when the macro is defined; all outputs are registered.
REQ-016 Prescaler count SHALL run 0..DIV-1 and wrap to 0 while busy, hold 0 in IDLE, and clear to 0 on every state entry; tick = (count == DIV-1).
REQ-017 In IDLE, start=1 with blink_num!=0 SHALL, at that edge, latch blink_num into blinks_left and enter ON, with led=1 and busy=1.
REQ-018 In IDLE, start=1 with blink_num==0 SHALL be ignored: no state change, no done, no busy.
REQ-019 The block SHALL ignore start while busy=1, and a changing blink_num SHALL NOT affect a running sequence.
REQ-020 ON SHALL last exactly ON_TICKS*DIV cycles, then go to OFF with led=0 and blinks_left decremented by 1 on that edge.
REQ-021 OFF SHALL last exactly OFF_TICKS*DIV cycles; if blinks_left!=0 it then enters ON, otherwise the sequence ends (REQ-022 or REQ-031).
REQ-022 At sequence end without a restart, the block SHALL enter IDLE with busy=0 and done=1 for exactly one cycle; done SHALL otherwise be 0.
REQ-023 Total busy time SHALL be blink_num*(ON_TICKS+OFF_TICKS)*DIV cycles.
REQ-024 A start in the cycle done=1 (already IDLE) SHALL be accepted normally, giving back-to-back sequences.
REQ-025 The tick-count register SHALL be sized for max(ON_TICKS, OFF_TICKS, PAUSE_TICKS), and the block SHALL NOT use overflow in count or tick arithmetic.

Reset
REQ-026 When rst=1 at an edge, the block SHALL force IDLE, led=0, busy=0, done=0, count=0, blinks_left=0, and clear the latched blink_num.
REQ-027 rst SHALL dominate start and every state, and take effect mid-sequence with no done pulse.
REQ-028 One cycle after rst deasserts, the block SHALL accept start.

Configuration
REQ-029 The feature SHALL be controlled by macro LED_BLINK_REPEAT_EN.
REQ-030 Without LED_BLINK_REPEAT_EN, PAUSE SHALL NOT exist, repeat SHALL be ignored, and behaviour SHALL follow REQ-022.
REQ-031 With LED_BLINK_REPEAT_EN and repeat=1 at sequence end, the block SHALL enter PAUSE instead of IDLE, with led=0, busy=1 and done=1 pulsed once.
REQ-032 After PAUSE_TICKS*DIV cycles, PAUSE SHALL reload blinks_left from the latched blink_num and enter ON.
REQ-033 If repeat=0 at sequence end, the block SHALL enter IDLE per REQ-022; repeat is sampled only at that point.

Verification (DIV=4, ON_TICKS=2, OFF_TICKS=1, PAUSE_TICKS=2)
REQ-034 Reset then start with blink_num=3 -> led high 8 cycles, low 4, three times; busy high 36 cycles; done pulses once; blinks_left steps 3,2,1,0.
REQ-035 start with blink_num=0 -> led, busy and done stay 0; count stays 0.
REQ-036 Second start during the first blink of a blink_num=2 sequence, with blink_num changed to 5 -> exactly 2 blinks, busy 24 cycles.
REQ-037 rst pulsed at cycle 10 of a blink_num=4 run -> next edge all outputs 0, no done; new start then runs a full sequence.
REQ-038 start asserted in the done cycle -> the second sequence's led rises on the following edge with no idle gap.
REQ-039 With LED_BLINK_REPEAT_EN, blink_num=1 and repeat=1 -> done pulses, led low 8 pause cycles, blink repeats; repeat dropped to 0 -> IDLE after the current sequence.

Source files
------------

// File: rtl/led_blink_seq.sv
// led_blink_seq: blinks an LED blink_num times per sequence using a tick prescaler.
// Each blink is ON_TICKS ticks lit followed by OFF_TICKS ticks dark, where one
// tick is DIV clock cycles. All outputs are registered.
// Optional feature macro: LED_BLINK_REPEAT_EN. When it is defined, a sequence
// that ends with repeat_req high pauses for PAUSE_TICKS ticks and then runs again.
// When it is undefined, repeat_req is ignored.
// The auto-restart request port is called repeat_req because "repeat" is a
// reserved word in SystemVerilog.

module led_blink_seq #(
   parameter int DIV         = 25000000,
   parameter int ON_TICKS    = 1,
   parameter int OFF_TICKS   = 1,
   parameter int PAUSE_TICKS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  blink_num,
   input  logic        repeat_req,
   output logic        led,
   output logic        busy,
   output logic        done,
   output logic [28:0] count,
   output logic [3:0]  blinks_left
);

   // The tick counter only has to reach the longest phase length.
   // PAUSE_TICKS is included so the same width serves both builds.
   localparam int MAX_A    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int MAX_T    = (MAX_A > PAUSE_TICKS) ? MAX_A : PAUSE_TICKS;
   localparam int TW       = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   localparam logic [28:0]   DIV_LAST   = 29'(DIV - 1);
   localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
`ifdef LED_BLINK_REPEAT_EN
   localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_TICKS - 1);
`endif

`ifdef LED_BLINK_REPEAT_EN
   typedef enum logic [1:0] {IDLE, ON, OFF, PAUSE} state_t;
`else
   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
`endif

   state_t          state;
   logic [TW-1:0]   tick_cnt;
   logic [3:0]      latched_num;
   logic            tick;

   // A tick is the last cycle of a prescaler period. The prescaler never counts
   // past DIV-1, so it cannot overflow.
   assign tick = (count == DIV_LAST);

`ifndef LED_BLINK_REPEAT_EN
   // Without the repeat feature, nothing reads the restart request or the
   // latched blink count. They are collected here so they are still consumed.
   logic [4:0] unused_inputs;
   assign unused_inputs = {repeat_req, latched_num};
`endif

   // This block is the sequencer FSM. It also drives the prescaler, the per-state
   // tick counter and all registered outputs. done defaults low and is raised
   // for exactly one cycle when a sequence ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         led         <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         count       <= '0;
         tick_cnt    <= '0;
         blinks_left <= '0;
         latched_num <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               count    <= '0;
               tick_cnt <= '0;
               if (start && (blink_num != 4'd0)) begin
                  latched_num <= blink_num;
                  blinks_left <= blink_num;
                  state       <= ON;
                  led         <= 1'b1;
                  busy        <= 1'b1;
               end
            end

            ON: begin
               if (tick) begin
                  count <= '0;
                  if (tick_cnt == ON_LAST) begin
                     tick_cnt    <= '0;
                     state       <= OFF;
                     led         <= 1'b0;
                     blinks_left <= blinks_left - 4'd1;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end else begin
                  count <= count + 29'd1;
               end
            end

            OFF: begin
               if (tick) begin
                  count <= '0;
                  if (tick_cnt == OFF_LAST) begin
                     tick_cnt <= '0;
                     if (blinks_left != 4'd0) begin
                        state <= ON;
                        led   <= 1'b1;
                     end else begin
`ifdef LED_BLINK_REPEAT_EN
                        if (repeat_req) begin
                           state <= PAUSE;
                           done  <= 1'b1;
                        end else begin
                           state <= IDLE;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end else begin
                  count <= count + 29'd1;
               end
            end

`ifdef LED_BLINK_REPEAT_EN
            PAUSE: begin
               if (tick) begin
                  count <= '0;
                  if (tick_cnt == PAUSE_LAST) begin
                     tick_cnt    <= '0;
                     blinks_left <= latched_num;
                     state       <= ON;
                     led         <= 1'b1;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end else begin
                  count <= count + 29'd1;
               end
            end
`endif

            default: begin
               state    <= IDLE;
               led      <= 1'b0;
               busy     <= 1'b0;
               count    <= '0;
               tick_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_blink_seq.sv
// tb_led_blink_seq: directed and randomized stimulus for led_blink_seq.
// The reference model tracks the time elapsed inside a sequence. It derives the
// LED level, busy, count and remaining blinks from that time with plain
// arithmetic. It follows LED_BLINK_REPEAT_EN the same way the design does.

module tb_led_blink_seq;

   localparam int DIV         = 4;
   localparam int ON_TICKS    = 2;
   localparam int OFF_TICKS   = 1;
   localparam int PAUSE_TICKS = 2;
   localparam int PERIOD      = (ON_TICKS + OFF_TICKS) * DIV;
   localparam int ON_CYC      = ON_TICKS * DIV;
   localparam int PAUSE_CYC   = PAUSE_TICKS * DIV;
`ifdef LED_BLINK_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  blink_num = 4'd0;
   logic        repeat_req = 1'b0;
   logic        led;
   logic        busy;
   logic        done;
   logic [28:0] count;
   logic [3:0]  blinks_left;

   int checks = 0;
   int errors = 0;
   int busy_cycles = 0;
   int done_pulses = 0;

   // Reference model state: whether a sequence is active, time within it,
   // and time within the pause.
   bit m_active = 1'b0;
   bit m_pause  = 1'b0;
   bit m_done   = 1'b0;
   int m_n  = 0;
   int m_t  = 0;
   int m_pt = 0;

   led_blink_seq #(
      .DIV(DIV), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .PAUSE_TICKS(PAUSE_TICKS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .blink_num(blink_num),
      .repeat_req(repeat_req), .led(led), .busy(busy), .done(done),
      .count(count), .blinks_left(blinks_left)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Advance the model across one rising edge, using the inputs seen at that edge.
   task automatic model_step(input bit r, input bit s, input int bn, input bit rp);
      m_done = 1'b0;
      if (r) begin
         m_active = 1'b0; m_pause = 1'b0; m_n = 0; m_t = 0; m_pt = 0;
      end else if (!m_active) begin
         if (s && bn != 0) begin
            m_active = 1'b1; m_pause = 1'b0; m_n = bn; m_t = 0;
         end
      end else if (m_pause) begin
         m_pt++;
         if (m_pt == PAUSE_CYC) begin
            m_pause = 1'b0; m_t = 0;
         end
      end else begin
         m_t++;
         if (m_t == m_n * PERIOD) begin
            m_done = 1'b1;
            if (REP_EN && rp) begin
               m_pause = 1'b1; m_pt = 0;
            end else begin
               m_active = 1'b0;
            end
         end
      end
   endtask

   function automatic logic [31:0] exp_led();
      return {31'd0, (m_active && !m_pause && ((m_t % PERIOD) < ON_CYC))};
   endfunction

   function automatic logic [31:0] exp_count();
      if (!m_active) return 32'd0;
      return m_pause ? 32'(m_pt % DIV) : 32'(m_t % DIV);
   endfunction

   function automatic logic [31:0] exp_left();
      if (!m_active || m_pause) return 32'd0;
      return 32'(m_n - m_t / PERIOD - (((m_t % PERIOD) >= ON_CYC) ? 1 : 0));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive inputs, take one clock edge, then compare every output with the model.
   task automatic applyStimulus(input bit r, input bit s, input logic [3:0] bn, input bit rp);
      rst = r; start = s; blink_num = bn; repeat_req = rp;
      @(posedge clk);
      model_step(r, s, int'(bn), rp);
      #1;
      checkOutput("led", {31'd0, led}, exp_led());
      checkOutput("busy", {31'd0, busy}, {31'd0, m_active});
      checkOutput("done", {31'd0, done}, {31'd0, m_done});
      checkOutput("count", {3'd0, count}, exp_count());
      checkOutput("blinks_left", {28'd0, blinks_left}, exp_left());
      busy_cycles += int'(busy);
      done_pulses += int'(done);
   endtask

   initial begin
      bit r, s, rp;
      logic [3:0] bn;
      int guard;

      // Reset state.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd7, 1'b0);

      // Three blinks, started on the first edge after reset is released.
      busy_cycles = 0; done_pulses = 0;
      applyStimulus(1'b0, 1'b1, 4'd3, 1'b0);
      repeat (40) applyStimulus(1'b0, 1'b0, 4'd3, 1'b0);
      checkOutput("busy_len_3", 32'(busy_cycles), 32'd36);
      checkOutput("done_once_3", 32'(done_pulses), 32'd1);

      // A zero blink count is ignored.
      busy_cycles = 0; done_pulses = 0;
      repeat (6) applyStimulus(1'b0, 1'b1, 4'd0, 1'b0);
      checkOutput("zero_no_busy", 32'(busy_cycles), 32'd0);

      // Start and blink_num changes made while busy have no effect.
      busy_cycles = 0;
      applyStimulus(1'b0, 1'b1, 4'd2, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
      repeat (30) applyStimulus(1'b0, 1'b0, 4'd5, 1'b0);
      checkOutput("busy_len_2", 32'(busy_cycles), 32'd24);

      // Reset in the middle of a run produces no done pulse. A full sequence follows.
      done_pulses = 0;
      applyStimulus(1'b0, 1'b1, 4'd4, 1'b0);
      repeat (9) applyStimulus(1'b0, 1'b0, 4'd4, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd4, 1'b0);
      checkOutput("rst_no_done", 32'(done_pulses), 32'd0);
      busy_cycles = 0; done_pulses = 0;
      applyStimulus(1'b0, 1'b1, 4'd4, 1'b0);
      repeat (50) applyStimulus(1'b0, 1'b0, 4'd4, 1'b0);
      checkOutput("busy_len_4", 32'(busy_cycles), 32'd48);
      checkOutput("done_once_4", 32'(done_pulses), 32'd1);

      // A start issued in the done cycle begins the next sequence back to back.
      applyStimulus(1'b0, 1'b1, 4'd1, 1'b0);
      guard = 0;
      while (!m_done && guard < 40) begin
         applyStimulus(1'b0, 1'b0, 4'd1, 1'b0);
         guard++;
      end
      checkOutput("b2b_done_seen", {31'd0, done}, 32'd1);
      applyStimulus(1'b0, 1'b1, 4'd1, 1'b0);
      checkOutput("b2b_led", {31'd0, led}, 32'd1);
      checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
      repeat (15) applyStimulus(1'b0, 1'b0, 4'd1, 1'b0);

      // Hold repeat high, then drop it. The block repeats or ignores it
      // depending on the build.
      done_pulses = 0;
      applyStimulus(1'b0, 1'b1, 4'd1, 1'b1);
      repeat (60) applyStimulus(1'b0, 1'b0, 4'd1, 1'b1);
      checkOutput("rep_done_pulses", 32'(done_pulses), REP_EN ? 32'd3 : 32'd1);
      repeat (40) applyStimulus(1'b0, 1'b0, 4'd1, 1'b0);
      checkOutput("rep_final_idle", {31'd0, busy}, 32'd0);

      // Randomized traffic: sparse starts, rare resets, slowly changing repeat.
      rp = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         s  = ($urandom_range(0, 7) == 0);
         bn = 4'($urandom_range(0, 15));
         if (i % 50 == 0) rp = 1'($urandom_range(0, 1));
         applyStimulus(r, s, bn, rp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
